// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: execute results vs. buffered load returns, plus pending-load scoreboard.
// Optional forwarding outputs (fwd1_hit, fwd2_hit, fwd_data) are enabled by defining WB_FWD_EN.
module regfile_wb_arbiter #(
  parameter int unsigned LD_FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIMIT  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  output logic        hazard,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
`ifdef WB_FWD_EN
  ,
  output logic        fwd1_hit,
  output logic        fwd2_hit,
  output logic [31:0] fwd_data
`endif
);

  localparam int unsigned AW = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   DEPTH_C = LD_FIFO_DEPTH[AW:0];
  localparam logic [SW-1:0] LIMIT_C = STARVE_LIMIT[SW-1:0];

  logic [4:0]    fifo_rd   [LD_FIFO_DEPTH];
  logic [31:0]   fifo_data [LD_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [SW-1:0] starve;
  logic [31:0]   pending, pending_nxt;

  logic        fifo_empty, fifo_full, push, pop, force_ld, grant_ex, grant_ld;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == DEPTH_C);
    ld_ready   = !fifo_full;
    push       = ld_valid && !fifo_full;
    force_ld   = (starve == LIMIT_C) && !fifo_empty;
    ex_ready   = !force_ld;
    grant_ex   = ex_valid && ex_ready;
    grant_ld   = !grant_ex && !fifo_empty;
    pop        = grant_ld;
    head_rd    = fifo_rd[rd_ptr];
    head_data  = fifo_data[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= ld_rd;
      fifo_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || fifo_empty || pop)
      starve <= '0;
    else if (starve != LIMIT_C)
      starve <= starve + 1'b1;
  end

  // Clear is applied before set so a re-issue to the same register wins.
  always_comb begin
    pending_nxt = pending;
    if (grant_ld) pending_nxt[head_rd] = 1'b0;
    if (ld_issue) pending_nxt[ld_issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  always_comb begin
    hazard = ((q_rs1 != '0) && pending[q_rs1]) || ((q_rs2 != '0) && pending[q_rs2]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (grant_ex) begin
      wb_we   <= (ex_rd != '0);
      wb_rd   <= ex_rd;
      wb_data <= ex_data;
    end else if (grant_ld) begin
      wb_we   <= (head_rd != '0);
      wb_rd   <= head_rd;
      wb_data <= head_data;
    end else begin
      wb_we   <= 1'b0;
    end
  end

`ifdef WB_FWD_EN
  always_comb begin
    fwd1_hit = wb_we && (wb_rd == q_rs1) && (q_rs1 != '0);
    fwd2_hit = wb_we && (wb_rd == q_rs2) && (q_rs2 != '0);
    fwd_data = wb_data;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (default parameters: depth 4, starve limit 3).
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  q_rs1, q_rs2;
  logic        hazard;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef WB_FWD_EN
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd_data;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.LD_FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .hazard(hazard),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef WB_FWD_EN
    , .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd_data(fwd_data)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    ex_valid = 1'b0; ex_rd = '0; ex_data = '0;
    ld_issue = 1'b0; ld_issue_rd = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    q_rs1 = '0; q_rs2 = '0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    q_rs1 = 5'd5; q_rs2 = 5'd31;
    settle();
    check_eq("rst_we",       wb_we,    0);
    check_eq("rst_rd",       wb_rd,    0);
    check_eq("rst_data",     wb_data,  0);
    check_eq("rst_ld_ready", ld_ready, 1);
    check_eq("rst_ex_ready", ex_ready, 1);
    check_eq("rst_hazard",   hazard,   0);
    q_rs1 = '0; q_rs2 = '0;

    // Execute-only write
    ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 32'h11;
    settle();
    check_eq("ex_ready", ex_ready, 1);
    tick();
    ex_valid = 1'b0;
    check_eq("ex_we",   wb_we,   1);
    check_eq("ex_rd",   wb_rd,   5);
    check_eq("ex_data", wb_data, 32'h11);

    // rd=0 grant is consumed but not written; then idle holds data
    ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'hFF;
    settle();
    check_eq("rd0_ready", ex_ready, 1);
    tick();
    ex_valid = 1'b0;
    check_eq("rd0_we", wb_we, 0);
    tick();
    check_eq("idle_we",   wb_we,   0);
    check_eq("idle_hold", wb_data, 32'hFF);

    // Load issue, hazard, return with no bypass
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    tick();
    ld_issue = 1'b0;
    q_rs1 = 5'd7; settle();
    check_eq("haz_rs1", hazard, 1);
    q_rs1 = 5'd0; q_rs2 = 5'd7; settle();
    check_eq("haz_rs2", hazard, 1);
    q_rs2 = 5'd3; settle();
    check_eq("haz_other", hazard, 0);
    q_rs1 = 5'd7; q_rs2 = 5'd0;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hABCD;
    settle();
    check_eq("ld_ready_idle", ld_ready, 1);
    tick();
    ld_valid = 1'b0;
    settle();
    check_eq("no_bypass_we", wb_we,  0);
    check_eq("haz_buffered", hazard, 1);
    tick();
    check_eq("ld_we",   wb_we,   1);
    check_eq("ld_rd",   wb_rd,   7);
    check_eq("ld_data", wb_data, 32'hABCD);
    settle();
    check_eq("ld_haz_clear", hazard, 0);
`ifdef WB_FWD_EN
    check_eq("fwd1_hit", fwd1_hit, 1);
    check_eq("fwd_data", fwd_data, 32'hABCD);
`endif
    tick();
    check_eq("after_ld_we", wb_we, 0);
    q_rs1 = '0;

    // Starvation: head waits 3 cycles, then forced
    ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h100;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h999;
    tick();
    ld_valid = 1'b0;
    check_eq("stv_ex0", wb_data, 32'h100);
    for (int k = 1; k <= 3; k++) begin
      ex_data = 32'h100 + 32'(k);
      settle();
      check_eq("stv_ready", ex_ready, 1);
      tick();
      check_eq("stv_ex_rd",   wb_rd,   3);
      check_eq("stv_ex_data", wb_data, 32'h100 + 32'(k));
    end
    settle();
    check_eq("stv_force", ex_ready, 0);
    ex_data = 32'h104;
    tick();
    check_eq("stv_ld_we",   wb_we,   1);
    check_eq("stv_ld_rd",   wb_rd,   9);
    check_eq("stv_ld_data", wb_data, 32'h999);
    settle();
    check_eq("stv_release", ex_ready, 1);
    tick();
    check_eq("stv_ex_after", wb_data, 32'h104);
    ex_valid = 1'b0;

    // Fill FIFO while execute is busy, then overlap push/pop and drain in order
    ex_valid = 1'b1; ex_rd = 5'd4; ex_data = 32'h40;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_rd = 5'(10 + i); ld_data = 32'hA0 + 32'(i);
      settle();
      check_eq("fill_ready", ld_ready, 1);
      tick();
    end
    ld_rd = 5'd14; ld_data = 32'hA4;
    settle();
    check_eq("full_ld_ready", ld_ready, 0);
    check_eq("full_force",    ex_ready, 0);
    tick();
    check_eq("full_pop_rd",   wb_rd,   10);
    check_eq("full_pop_data", wb_data, 32'hA0);
    ex_valid = 1'b0;
    settle();
    check_eq("after_pop_ready", ld_ready, 1);
    tick();
    check_eq("pp1_rd", wb_rd, 11);
    ld_rd = 5'd15; ld_data = 32'hA5;
    settle();
    check_eq("pp2_ready", ld_ready, 1);
    tick();
    check_eq("pp2_rd", wb_rd, 12);
    ld_valid = 1'b0;
    settle();
    check_eq("pp_count_kept", ld_ready, 1);
    for (int i = 3; i <= 5; i++) begin
      tick();
      check_eq("drain_we",   wb_we,   1);
      check_eq("drain_rd",   wb_rd,   32'(10 + i));
      check_eq("drain_data", wb_data, 32'hA0 + 32'(i));
    end
    tick();
    check_eq("drained_we", wb_we, 0);

    // Re-issue on the same register as a granted return: set wins
    ld_issue = 1'b1; ld_issue_rd = 5'd20;
    ld_valid = 1'b1; ld_rd = 5'd20; ld_data = 32'h2020;
    tick();
    ld_valid = 1'b0;
    tick();
    ld_issue = 1'b0;
    check_eq("setwin_rd", wb_rd, 20);
    check_eq("setwin_we", wb_we, 1);
    q_rs1 = 5'd20; settle();
    check_eq("setwin_haz", hazard, 1);

    // Reset mid-operation
    q_rs1 = '0;
    ex_valid = 1'b1; ex_rd = 5'd2; ex_data = 32'h55;
    ld_issue = 1'b1; ld_issue_rd = 5'd21;
    ld_valid = 1'b1; ld_rd = 5'd21; ld_data = 32'h21;
    tick();
    ld_issue_rd = 5'd22; ld_rd = 5'd22; ld_data = 32'h22;
    tick();
    clear_inputs();
    q_rs1 = 5'd21; q_rs2 = 5'd22;
    settle();
    check_eq("pre_rst_haz", hazard, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mrst_we", wb_we, 0);
    settle();
    check_eq("mrst_ld_ready", ld_ready, 1);
    check_eq("mrst_haz", hazard, 0);
    q_rs1 = 5'd20; q_rs2 = 5'd7; settle();
    check_eq("mrst_haz2", hazard, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("mrst_no_stale", wb_we, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
